// File: rtl/cache_perf_counter_if.sv
// Bus bundle for cache_perf_counter: per-channel event strobes, control,
// snapshot request and the registered snapshot/flag outputs.
interface cache_perf_counter_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0] acc_i;
    logic [NUM_CH-1:0] hit_i;
    logic [NUM_CH-1:0] miss_i;
    logic              clear_i;
    logic              freeze_i;
    logic              snap_i;
    logic [SEL_W-1:0]  sel_i;
    logic [CNT_W-1:0]  acc_o;
    logic [CNT_W-1:0]  hit_o;
    logic [CNT_W-1:0]  miss_o;
    logic              snap_valid_o;
    logic [NUM_CH-1:0] ovf_o;
    logic [NUM_CH-1:0] err_o;

    // Cache-controller / software side: drives events and requests.
    modport master (
        output acc_i, hit_i, miss_i, clear_i, freeze_i, snap_i, sel_i,
        input  acc_o, hit_o, miss_o, snap_valid_o, ovf_o, err_o
    );

    // Counter block side.
    modport slave (
        input  acc_i, hit_i, miss_i, clear_i, freeze_i, snap_i, sel_i,
        output acc_o, hit_o, miss_o, snap_valid_o, ovf_o, err_o
    );
endinterface

// File: rtl/cache_perf_counter.sv
// Per-channel access/hit/miss event counters with sticky overflow and
// protocol-error flags, read out through a single registered snapshot port.
module cache_perf_counter #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1,
    parameter int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    cache_perf_counter_if.slave bus
);

    typedef logic [CNT_W-1:0] cnt_t;

    // Returns {overflow, next_value}; an increment at all-ones either
    // sticks or wraps depending on SATURATE, and flags overflow either way.
    function automatic logic [CNT_W:0] bump(input cnt_t v, input logic en);
        logic [CNT_W:0] r;
        if (!en) begin
            r = {1'b0, v};
        end else if (&v) begin
            r = (SATURATE != 0) ? {1'b1, v} : {1'b1, {CNT_W{1'b0}}};
        end else begin
            r = {1'b0, v + cnt_t'(1'b1)};
        end
        return r;
    endfunction

    cnt_t              acc_cnt_q  [NUM_CH];
    cnt_t              acc_cnt_d  [NUM_CH];
    cnt_t              hit_cnt_q  [NUM_CH];
    cnt_t              hit_cnt_d  [NUM_CH];
    cnt_t              miss_cnt_q [NUM_CH];
    cnt_t              miss_cnt_d [NUM_CH];
    logic [CNT_W:0]    acc_b_s    [NUM_CH];
    logic [CNT_W:0]    hit_b_s    [NUM_CH];
    logic [CNT_W:0]    miss_b_s   [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] err_q, err_d;
    logic [NUM_CH-1:0] ovf_ev_s;
    logic [NUM_CH-1:0] err_ev_s;
    logic [NUM_CH-1:0] acc_en_s;
    logic [NUM_CH-1:0] hit_en_s;
    logic [NUM_CH-1:0] miss_en_s;
    cnt_t              acc_o_q, acc_o_d;
    cnt_t              hit_o_q, hit_o_d;
    cnt_t              miss_o_q, miss_o_d;
    logic              snap_valid_q, snap_valid_d;

    // A hit/miss only counts when it is a clean, unambiguous access result;
    // conflicting or orphaned strobes are flagged as errors instead.
    assign err_ev_s  = (bus.hit_i & bus.miss_i)
                     | ((bus.hit_i | bus.miss_i) & ~bus.acc_i);
    assign acc_en_s  = bus.freeze_i ? {NUM_CH{1'b0}} : bus.acc_i;
    assign hit_en_s  = bus.freeze_i ? {NUM_CH{1'b0}}
                                    : (bus.hit_i & bus.acc_i & ~bus.miss_i);
    assign miss_en_s = bus.freeze_i ? {NUM_CH{1'b0}}
                                    : (bus.miss_i & bus.acc_i & ~bus.hit_i);

    // Candidate next value and overflow indication for every counter.
    always_comb begin
        ovf_ev_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            acc_b_s[c]  = bump(acc_cnt_q[c],  acc_en_s[c]);
            hit_b_s[c]  = bump(hit_cnt_q[c],  hit_en_s[c]);
            miss_b_s[c] = bump(miss_cnt_q[c], miss_en_s[c]);
            ovf_ev_s[c] = acc_b_s[c][CNT_W] | hit_b_s[c][CNT_W] | miss_b_s[c][CNT_W];
        end
    end

    // Counter and sticky-flag update; clear overrides everything else.
    always_comb begin
        ovf_d = ovf_q;
        err_d = err_q;
        for (int c = 0; c < NUM_CH; c++) begin
            acc_cnt_d[c]  = acc_cnt_q[c];
            hit_cnt_d[c]  = hit_cnt_q[c];
            miss_cnt_d[c] = miss_cnt_q[c];
        end
        if (bus.clear_i) begin
            ovf_d = '0;
            err_d = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_cnt_d[c]  = '0;
                hit_cnt_d[c]  = '0;
                miss_cnt_d[c] = '0;
            end
        end else begin
            ovf_d = ovf_q | ovf_ev_s;
            err_d = err_q | err_ev_s;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_cnt_d[c]  = acc_b_s[c][CNT_W-1:0];
                hit_cnt_d[c]  = hit_b_s[c][CNT_W-1:0];
                miss_cnt_d[c] = miss_b_s[c][CNT_W-1:0];
            end
        end
    end

    // Snapshot mux: captures pre-edge counter values; out-of-range select reads 0.
    always_comb begin
        acc_o_d      = acc_o_q;
        hit_o_d      = hit_o_q;
        miss_o_d     = miss_o_q;
        snap_valid_d = bus.snap_i;
        if (bus.snap_i) begin
            acc_o_d  = '0;
            hit_o_d  = '0;
            miss_o_d = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.sel_i == SEL_W'(c)) begin
                    acc_o_d  = acc_cnt_q[c];
                    hit_o_d  = hit_cnt_q[c];
                    miss_o_d = miss_cnt_q[c];
                end else begin
                    acc_o_d  = acc_o_d;
                end
            end
        end else begin
            snap_valid_d = 1'b0;
        end
    end

    // State registers; reset discards counters, flags and any pending snapshot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_cnt_q[c]  <= '0;
                hit_cnt_q[c]  <= '0;
                miss_cnt_q[c] <= '0;
            end
            ovf_q        <= '0;
            err_q        <= '0;
            acc_o_q      <= '0;
            hit_o_q      <= '0;
            miss_o_q     <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_cnt_q[c]  <= acc_cnt_d[c];
                hit_cnt_q[c]  <= hit_cnt_d[c];
                miss_cnt_q[c] <= miss_cnt_d[c];
            end
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            acc_o_q      <= acc_o_d;
            hit_o_q      <= hit_o_d;
            miss_o_q     <= miss_o_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign bus.acc_o        = acc_o_q;
    assign bus.hit_o        = hit_o_q;
    assign bus.miss_o       = miss_o_q;
    assign bus.snap_valid_o = snap_valid_q;
    assign bus.ovf_o        = ovf_q;
    assign bus.err_o        = err_q;

endmodule

// File: tb/tb_cache_perf_counter.sv
// Self-checking bench: a saturating 4-channel instance and a wrapping
// 3-channel instance (8-bit counters) share one stimulus stream and are
// compared every cycle against an unbounded-integer reference model.
module tb_cache_perf_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] acc, hit, miss;
    logic       clear, freeze, snap;
    logic [1:0] sel;
    int         passed = 0;
    int         total  = 0;

    // Reference model: true event counts per DUT (0 = sat/4ch, 1 = wrap/3ch).
    int n_acc  [2][4];
    int n_hit  [2][4];
    int n_miss [2][4];
    bit err_m  [2][4];
    int e_acc  [2];
    int e_hit  [2];
    int e_miss [2];
    bit e_sv   [2];

    always #5 clk = ~clk;

    cache_perf_counter_if #(.NUM_CH(4), .CNT_W(8), .SEL_W(2)) ifa ();
    cache_perf_counter_if #(.NUM_CH(3), .CNT_W(8), .SEL_W(2)) ifb ();

    assign ifa.acc_i = acc;       assign ifb.acc_i = acc[2:0];
    assign ifa.hit_i = hit;       assign ifb.hit_i = hit[2:0];
    assign ifa.miss_i = miss;     assign ifb.miss_i = miss[2:0];
    assign ifa.clear_i = clear;   assign ifb.clear_i = clear;
    assign ifa.freeze_i = freeze; assign ifb.freeze_i = freeze;
    assign ifa.snap_i = snap;     assign ifb.snap_i = snap;
    assign ifa.sel_i = sel;       assign ifb.sel_i = sel;

    cache_perf_counter #(.NUM_CH(4), .CNT_W(8), .SATURATE(1)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave));
    cache_perf_counter #(.NUM_CH(3), .CNT_W(8), .SATURATE(0)) dut_wrap (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave));

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    // What an 8-bit counter shows for a true count n.
    function automatic int shown(input int d, input int n);
        if (d == 0) return (n > 255) ? 255 : n;
        return n % 256;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 4; c++) begin
                n_acc[d][c] = 0; n_hit[d][c] = 0; n_miss[d][c] = 0; err_m[d][c] = 1'b0;
            end
            e_acc[d] = 0; e_hit[d] = 0; e_miss[d] = 0; e_sv[d] = 1'b0;
        end
    endtask

    // Apply the current inputs to the model as one clock edge.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            e_sv[d] = snap;
            if (snap) begin
                if (int'(sel) < nch(d)) begin
                    e_acc[d]  = shown(d, n_acc[d][sel]);
                    e_hit[d]  = shown(d, n_hit[d][sel]);
                    e_miss[d] = shown(d, n_miss[d][sel]);
                end else begin
                    e_acc[d] = 0; e_hit[d] = 0; e_miss[d] = 0;
                end
            end
            for (int c = 0; c < nch(d); c++) begin
                if (clear) begin
                    n_acc[d][c] = 0; n_hit[d][c] = 0; n_miss[d][c] = 0; err_m[d][c] = 1'b0;
                end else begin
                    if ((hit[c] && miss[c]) || ((hit[c] || miss[c]) && !acc[c]))
                        err_m[d][c] = 1'b1;
                    if (!freeze) begin
                        if (acc[c]) n_acc[d][c]++;
                        if (acc[c] && hit[c] && !miss[c]) n_hit[d][c]++;
                        if (acc[c] && miss[c] && !hit[c]) n_miss[d][c]++;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        logic [3:0] eo [2];
        logic [3:0] ee [2];
        for (int d = 0; d < 2; d++) begin
            eo[d] = 4'b0000; ee[d] = 4'b0000;
            for (int c = 0; c < nch(d); c++) begin
                eo[d][c] = (n_acc[d][c] > 255) || (n_hit[d][c] > 255) || (n_miss[d][c] > 255);
                ee[d][c] = err_m[d][c];
            end
        end
        chk({ph, ":sat_valid"},  32'(ifa.snap_valid_o), 32'(e_sv[0]));
        chk({ph, ":sat_acc"},    32'(ifa.acc_o),        32'(e_acc[0]));
        chk({ph, ":sat_hit"},    32'(ifa.hit_o),        32'(e_hit[0]));
        chk({ph, ":sat_miss"},   32'(ifa.miss_o),       32'(e_miss[0]));
        chk({ph, ":sat_ovf"},    32'(ifa.ovf_o),        32'(eo[0]));
        chk({ph, ":sat_err"},    32'(ifa.err_o),        32'(ee[0]));
        chk({ph, ":wrap_valid"}, 32'(ifb.snap_valid_o), 32'(e_sv[1]));
        chk({ph, ":wrap_acc"},   32'(ifb.acc_o),        32'(e_acc[1]));
        chk({ph, ":wrap_hit"},   32'(ifb.hit_o),        32'(e_hit[1]));
        chk({ph, ":wrap_miss"},  32'(ifb.miss_o),       32'(e_miss[1]));
        chk({ph, ":wrap_ovf"},   32'(ifb.ovf_o),        32'(eo[1][2:0]));
        chk({ph, ":wrap_err"},   32'(ifb.err_o),        32'(ee[1][2:0]));
    endtask

    task automatic idle();
        acc = 4'b0000; hit = 4'b0000; miss = 4'b0000;
        clear = 1'b0; freeze = 1'b0; snap = 1'b0; sel = 2'd0;
    endtask

    task automatic cycle(input string ph);
        model_step();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Basic counting on channel 0.
        for (int i = 0; i < 5; i++) begin idle(); acc = 4'b0001; hit = 4'b0001; cycle("basic_hit"); end
        for (int i = 0; i < 3; i++) begin idle(); acc = 4'b0001; miss = 4'b0001; cycle("basic_miss"); end
        idle(); snap = 1'b1; sel = 2'd0; cycle("basic_snap");
        chk("basic_acc8", 32'(ifa.acc_o), 32'd8);
        chk("basic_hit5", 32'(ifa.hit_o), 32'd5);
        chk("basic_miss3", 32'(ifa.miss_o), 32'd3);
        idle(); cycle("basic_pulse_end");

        // Channel independence, back-to-back snapshots incl. out-of-range on wrap DUT.
        idle(); clear = 1'b1; cycle("ind_clear");
        for (int i = 0; i < 7; i++) begin idle(); acc = 4'b0100; hit = 4'b0100; cycle("ind_evt"); end
        for (int s = 0; s < 4; s++) begin idle(); snap = 1'b1; sel = 2'(s); cycle("ind_snap"); end
        chk("ind_sel3_wrap_zero", 32'(ifb.acc_o), 32'd0);
        idle(); cycle("ind_end");

        // Protocol errors on channel 1.
        idle(); clear = 1'b1; cycle("err_clear");
        idle(); hit = 4'b0010; cycle("err_orphan");
        chk("err_flag1", 32'(ifa.err_o), 32'h2);
        idle(); acc = 4'b0010; hit = 4'b0010; miss = 4'b0010; cycle("err_both");
        idle(); snap = 1'b1; sel = 2'd1; cycle("err_snap");
        chk("err_snap_acc1", 32'(ifa.acc_o), 32'd1);

        // Saturation vs wrap with 260 accesses.
        idle(); clear = 1'b1; cycle("sat_clear");
        for (int i = 0; i < 260; i++) begin idle(); acc = 4'b0001; cycle("sat_evt"); end
        idle(); snap = 1'b1; sel = 2'd0; cycle("sat_snap");
        chk("sat_acc255", 32'(ifa.acc_o), 32'd255);
        chk("wrap_acc4", 32'(ifb.acc_o), 32'd4);

        // Clear and freeze interplay.
        idle(); clear = 1'b1; cycle("frz_clear");
        for (int i = 0; i < 10; i++) begin idle(); acc = 4'b0001; cycle("frz_cnt"); end
        for (int i = 0; i < 4; i++) begin idle(); freeze = 1'b1; acc = 4'b0001; cycle("frz_hold"); end
        idle(); clear = 1'b1; snap = 1'b1; acc = 4'b0001; cycle("frz_clr_snap");
        chk("frz_snap10", 32'(ifa.acc_o), 32'd10);
        idle(); snap = 1'b1; cycle("frz_snap0");
        chk("frz_after_clear0", 32'(ifb.acc_o), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            acc = 4'($urandom);
            hit = acc & 4'($urandom);
            miss = acc & ~hit & 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                hit = 4'($urandom); miss = 4'($urandom);
            end
            clear  = ($urandom_range(0, 60) == 0);
            freeze = ($urandom_range(0, 9) == 0);
            snap   = ($urandom_range(0, 2) == 0);
            sel    = 2'($urandom);
            cycle("rand");
        end

        // Asynchronous reset between edges with a snapshot pending.
        idle(); acc = 4'b0111; hit = 4'b0011; cycle("arst_fill");
        snap = 1'b1; sel = 2'd0; acc = 4'b0111;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst_now");
        @(posedge clk);
        #1;
        check_all("arst_hold");
        #2 rst_n = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) cycle("arst_release");
        idle(); snap = 1'b1; sel = 2'd0; cycle("arst_snap");
        idle(); cycle("done");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_perf_counter.md
# cache_perf_counter

Parametrised event-counting block for the multi-level cache hierarchy. It tallies accesses, hits and misses independently for each of NUM_CH cache channels, for example L1 and L2, or per-way instances. It exposes the tallies through a single snapshot port, so the RISC-V top level can route cache statistics to the I/O registers without widening the port list per level. It sits beside the cache controllers and observes their one-cycle event strobes; it never back-pressures them.

## Interface
- NUM_CH, 2: number of independent counter channels (1..16).
- CNT_W, 32: width of every counter and snapshot output (8..64).
- SATURATE, 1: 1 = counters stick at all-ones; 0 = counters wrap to 0.
- SEL_W, $clog2(NUM_CH) (minimum 1): width of the channel select.

- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- acc_i  in  NUM_CH  per-channel access strobe, one event per high cycle.
- hit_i  in  NUM_CH  per-channel hit strobe.
- miss_i  in  NUM_CH  per-channel miss strobe.
- clear_i  in  1  synchronous clear of all counters and sticky flags.
- freeze_i  in  1  hold all counters; events ignored while high.
- snap_i  in  1  snapshot request.
- sel_i  in  SEL_W  channel to snapshot, sampled with snap_i.
- acc_o  out  CNT_W  snapshotted access count.
- hit_o  out  CNT_W  snapshotted hit count.
- miss_o  out  CNT_W  snapshotted miss count.
- snap_valid_o  out  1  one-cycle pulse: snapshot outputs updated.
- ovf_o  out  NUM_CH  sticky per-channel overflow/saturation flag.
- err_o  out  NUM_CH  sticky per-channel protocol-error flag.

## Operation
- Each channel holds three CNT_W counters: acc, hit, miss.
- Counter updates, per channel and per cycle, when freeze_i=0 and clear_i=0:
  - acc increments when acc_i[c]=1.
  - hit increments when hit_i[c]=1 and acc_i[c]=1 and miss_i[c]=0.
  - miss increments when miss_i[c]=1 and acc_i[c]=1 and hit_i[c]=0.
- Protocol error on a channel:
  - Condition: (hit_i[c] & miss_i[c]) | ((hit_i[c] | miss_i[c]) & ~acc_i[c]).
  - Sets err_o[c].
  - acc still counts if acc_i[c]=1; hit and miss do not count that cycle.
  - Errors are checked even while freeze_i=1.
- Counter at all-ones plus an increment:
  - SATURATE=1: holds all-ones.
  - SATURATE=0: becomes 0.
  - Either mode: sets ovf_o[c].
- clear_i=1:
  - All counters, ovf_o and err_o go to 0 at the next edge.
  - clear_i has priority over increments, freeze_i and error detection in the same cycle.
- Snapshot:
  - snap_i=1 with sel_i<NUM_CH: acc_o/hit_o/miss_o load the selected channel's counter values as they were before that edge (pre-increment, pre-clear).
  - sel_i>=NUM_CH: outputs load 0.
  - snap_valid_o pulses either way.
  - Snapshot outputs hold between requests and are unaffected by clear_i.
  - Back-to-back snap_i is legal: one update and one snap_valid_o pulse per request cycle.

## Timing
- Reset (rst_ni=0, asynchronous), all of the following go to 0 immediately:
  - all counters;
  - acc_o, hit_o, miss_o;
  - snap_valid_o;
  - ovf_o, err_o.
- Reset release is synchronous to clk_i; the first event is counted on the first rising edge with rst_ni=1.
- Event to counter update latency: 1 cycle.
- snap_i to outputs: 1 cycle. snap_valid_o is high in the same cycle the new values appear, for exactly one cycle.
- Event visibility in a snapshot:
  - An event in cycle N appears in a snapshot requested in cycle N+1 or later.
  - An event in the same cycle as snap_i is not included.
- Reset mid-operation discards any pending snapshot; no snap_valid_o pulse follows reset release.
- No combinational path from any input to any output.

## Test plan
- Reset and basic counting:
  - Stimulus: reset; channel 0 gets 5 cycles acc+hit, then 3 cycles acc+miss; then snap_i with sel_i=0.
  - Response: acc_o=8, hit_o=5, miss_o=3, snap_valid_o pulses one cycle; err_o=0, ovf_o=0.
- Channel independence (NUM_CH=4):
  - Stimulus: drive 7 acc+hit on channel 2 only; snapshot channels 0..3 back-to-back.
  - Response: channel 2 reads 7/7/0, others read 0/0/0; four snap_valid_o pulses.
- Protocol errors:
  - Stimulus: channel 1 gets hit_i=1 with acc_i=0 for one cycle, then acc+hit+miss for one cycle.
  - Response: err_o[1]=1 after the first cycle; snapshot reads acc=1, hit=0, miss=0.
- Saturation vs wrap (CNT_W=8):
  - Stimulus: 260 acc strobes on channel 0.
  - Response, SATURATE=1: acc=255, ovf_o[0]=1.
  - Response, SATURATE=0: acc=4, ovf_o[0]=1.
- Clear and freeze interplay:
  - Stimulus: 10 accesses; freeze_i with 4 more accesses; then clear_i together with snap_i and acc_i in one cycle; then snapshot again.
  - Response: first snapshot reads acc=10; second reads 0; ovf_o and err_o are 0.
- Async reset mid-run:
  - Stimulus: assert rst_ni=0 between edges while counters are non-zero and snap_i is pending.
  - Response: all outputs 0 immediately; no snap_valid_o pulse after release.
